exe_stage: RTL and testbench
============================

# exe_stage

Execute stage of the 5-stage LoongArch pipeline, between the decode stage and the memory stage. It latches the decoded bundle through a valid/allowin handshake and computes the 12-op ALU result. It issues the data-SRAM request for `ld.w`/`st.w` and exports a forwarding bundle back to decode for bypass and load-use stall detection.

## Interface
Parameters:
- `ID2EXE_LEN`, 148: width of decode bundle `{alu_op[11:0], res_from_mem, alu_src1[31:0], alu_src2[31:0], mem_we, rf_we, rf_waddr[4:0], rkd_value[31:0], pc[31:0]}`, MSB first.
- `EXE2MEM_LEN`, 71: width of memory bundle `{res_from_mem, rf_we, rf_waddr[4:0], alu_result[31:0], pc[31:0]}`, MSB first.

Ports:
- Reset is `resetn`, synchronous, active-low; the clock is `clk`.
- `clk`  in  1  clock.
- `resetn`  in  1  synchronous active-low reset.
- `id_to_exe_valid`  in  1  decode holds a valid instruction for this stage.
- `id_to_exe_zip`  in  ID2EXE_LEN  decode bundle.
- `exe_allowin`  out  1  this stage accepts a bundle this cycle.
- `mem_allowin`  in  1  memory stage accepts a bundle.
- `exe_to_mem_valid`  out  1  bundle valid toward memory stage.
- `exe_to_mem_zip`  out  EXE2MEM_LEN  memory bundle.
- `exe_rf_zip`  out  39  `{res_from_mem, rf_we, rf_waddr, alu_result}` forwarded to decode.
- `data_sram_en`  out  1  data SRAM enable.
- `data_sram_we`  out  4  byte write enables.
- `data_sram_addr`  out  32  byte address.
- `data_sram_wdata`  out  32  store data.
- `exe_inst_cnt`  out  32  retired-to-memory counter; present only with `EXE_PERF_CNT_EN`.

## Operation
- `exe_valid` is a register. The pipeline register loads the bundle when `id_to_exe_valid & exe_allowin`.
- `exe_ready_go` = 1, because every ALU op is single-cycle.
- `exe_allowin` = `~exe_valid | mem_allowin`.
- `exe_to_mem_valid` = `exe_valid`.
- `exe_valid` update rule: when `exe_allowin` is 1, it takes `id_to_exe_valid`; otherwise it holds.
- ALU: `alu_op` is one-hot. Bit assignment:
  - 0 add, 1 sub, 2 slt (signed), 3 sltu.
  - 4 and, 5 nor, 6 or, 7 xor.
  - 8 sll, 9 srl, 10 sra; the shift amount is `src2[4:0]`.
  - 11 lui: result = `src2`.
- All-zero `alu_op` gives result 0. Adds and subs are mod 2^32, with no overflow trap.
- slt/sltu produce `{31'b0, flag}`. Implement them from one 33-bit adder that computes `src1 + ~src2 + 1`, shared with sub.
- Memory request:
  - `data_sram_en` = `exe_valid & (res_from_mem | mem_we)`.
  - `data_sram_we` = `{4{exe_valid & mem_we}}`.
  - `data_sram_addr` = `alu_result`.
  - `data_sram_wdata` = `rkd_value`.
- The request is re-issued every cycle while the stage is held. This is idempotent for a synchronous SRAM, and read data is valid in the cycle after the bundle moves to memory.
- Forwarding: the `exe_rf_zip` bits `res_from_mem` and `rf_we` are ANDed with `exe_valid`. `rf_waddr` and `alu_result` are passed unqualified.

## Timing
- All outputs are combinational from the pipeline register, so latency is 1 cycle from acceptance to `exe_to_mem_valid`.
- Reset: `exe_valid` = 0, so `exe_to_mem_valid`, `data_sram_en`, `data_sram_we` and the forward-zip enables are all 0. `exe_inst_cnt` = 0. The data fields are don't-care.
- Simultaneous handoff: with a full stage, `mem_allowin` = 1 and a new valid input, the stage hands off and loads in the same edge, giving full throughput.
- Back-pressure: with `mem_allowin` = 0 and `exe_valid` = 1, the register and all outputs hold stable.
- Flush: decode squashes its own `id_valid` on a taken branch. This stage has no flush input.
- Reset mid-transfer: the bundle is dropped, and no SRAM write occurs in the reset cycle.

## Configuration
- `EXE_PERF_CNT_EN` defined:
  - Port `exe_inst_cnt` exists.
  - It increments by 1 on each cycle with `exe_valid & mem_allowin`, wraps at 2^32, and is cleared by reset.
- `EXE_PERF_CNT_EN` undefined: the port and the counter logic are absent. All other behaviour is identical.

## Test plan
- add: src1=0x7FFFFFFF, src2=1, op bit0, rf_we, waddr 5 -> next cycle `exe_to_mem_zip` alu_result=0x80000000 and `exe_rf_zip`=`{0,1,5,0x80000000}`.
- slt/sltu: src1=0xFFFFFFFF, src2=1 -> slt gives 1, sltu gives 0. sra with src1=0x80000000, src2=0x1F -> 0xFFFFFFFF.
- Store: mem_we, src1=0x1000, src2=0x8, rkd=0xDEADBEEF -> `data_sram_en`=1, `we`=4'hF, `addr`=0x1008, `wdata`=0xDEADBEEF for exactly the cycles `exe_valid`=1.
- Back-pressure: hold `mem_allowin`=0 for 3 cycles with a load in the stage -> `exe_allowin`=0 and all outputs stable. Release -> the next bundle loads on the same edge, and the `exe_rf_zip` res_from_mem bit drops if the new bundle is not a load.
- Reset mid-stream: assert resetn=0 with a valid store inside -> the next cycle `exe_valid`=0 and `data_sram_we`=0, and (with the macro) `exe_inst_cnt`=0.
- Counter: with `EXE_PERF_CNT_EN`, push 10 bundles with 2 stall cycles interleaved -> `exe_inst_cnt`=10.

Source files
------------

// File: rtl/exe_stage.sv
// Execute stage: pipeline register, 12-op ALU, data-SRAM request and decode forwarding.
// Optional retired-instruction counter enabled by defining EXE_PERF_CNT_EN.
module exe_stage #(
    parameter int ID2EXE_LEN  = 148,
    parameter int EXE2MEM_LEN = 71
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   id_to_exe_valid,
    input  logic [ID2EXE_LEN-1:0]  id_to_exe_zip,
    output logic                   exe_allowin,
    input  logic                   mem_allowin,
    output logic                   exe_to_mem_valid,
    output logic [EXE2MEM_LEN-1:0] exe_to_mem_zip,
    output logic [38:0]            exe_rf_zip,
`ifdef EXE_PERF_CNT_EN
    output logic [31:0]            exe_inst_cnt,
`endif
    output logic                   data_sram_en,
    output logic [3:0]             data_sram_we,
    output logic [31:0]            data_sram_addr,
    output logic [31:0]            data_sram_wdata
);

    logic                  exe_valid_q;
    logic [ID2EXE_LEN-1:0] exe_zip_q;
    logic                  exe_ready_go;

    logic [11:0] alu_op;
    logic        res_from_mem;
    logic [31:0] alu_src1;
    logic [31:0] alu_src2;
    logic        mem_we;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rkd_value;
    logic [31:0] exe_pc;
    logic [31:0] alu_result;

    assign {alu_op, res_from_mem, alu_src1, alu_src2, mem_we, rf_we,
            rf_waddr, rkd_value, exe_pc} = exe_zip_q;

    assign exe_ready_go     = 1'b1;
    assign exe_allowin      = ~exe_valid_q | (exe_ready_go & mem_allowin);
    assign exe_to_mem_valid = exe_valid_q & exe_ready_go;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            exe_valid_q <= 1'b0;
        end else if (exe_allowin) begin
            exe_valid_q <= id_to_exe_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (id_to_exe_valid && exe_allowin) begin
            exe_zip_q <= id_to_exe_zip;
        end
    end

    // sub, slt and sltu share one adder computing src1 + ~src2 + 1
    logic        adder_inv;
    logic [31:0] adder_b;
    logic [32:0] adder_sum;
    logic        slt_flag;
    logic        sltu_flag;
    logic [4:0]  shamt;

    assign adder_inv = alu_op[1] | alu_op[2] | alu_op[3];
    assign adder_b   = adder_inv ? ~alu_src2 : alu_src2;
    assign adder_sum = {1'b0, alu_src1} + {1'b0, adder_b} + {32'd0, adder_inv};
    assign slt_flag  = (alu_src1[31] & ~alu_src2[31])
                     | (~(alu_src1[31] ^ alu_src2[31]) & adder_sum[31]);
    assign sltu_flag = ~adder_sum[32];
    assign shamt     = alu_src2[4:0];

    always_comb begin
        alu_result = 32'd0;
        if (alu_op[0] | alu_op[1]) alu_result = alu_result | adder_sum[31:0];
        if (alu_op[2])  alu_result = alu_result | {31'd0, slt_flag};
        if (alu_op[3])  alu_result = alu_result | {31'd0, sltu_flag};
        if (alu_op[4])  alu_result = alu_result | (alu_src1 & alu_src2);
        if (alu_op[5])  alu_result = alu_result | ~(alu_src1 | alu_src2);
        if (alu_op[6])  alu_result = alu_result | (alu_src1 | alu_src2);
        if (alu_op[7])  alu_result = alu_result | (alu_src1 ^ alu_src2);
        if (alu_op[8])  alu_result = alu_result | (alu_src1 << shamt);
        if (alu_op[9])  alu_result = alu_result | (alu_src1 >> shamt);
        if (alu_op[10]) alu_result = alu_result | 32'($signed(alu_src1) >>> shamt);
        if (alu_op[11]) alu_result = alu_result | alu_src2;
    end

    assign exe_to_mem_zip = {res_from_mem, rf_we, rf_waddr, alu_result, exe_pc};
    assign exe_rf_zip     = {exe_valid_q & res_from_mem, exe_valid_q & rf_we,
                             rf_waddr, alu_result};

    // Write strobes are masked during reset so a held store cannot land in the reset cycle
    assign data_sram_en    = exe_valid_q & (res_from_mem | mem_we);
    assign data_sram_we    = {4{exe_valid_q & mem_we & resetn}};
    assign data_sram_addr  = alu_result;
    assign data_sram_wdata = rkd_value;

`ifdef EXE_PERF_CNT_EN
    logic [31:0] inst_cnt_q;
    logic [31:0] inst_cnt_d;

    assign inst_cnt_d = (exe_valid_q & mem_allowin) ? inst_cnt_q + 32'd1 : inst_cnt_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            inst_cnt_q <= 32'd0;
        end else begin
            inst_cnt_q <= inst_cnt_d;
        end
    end

    assign exe_inst_cnt = inst_cnt_q;
`endif

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: directed scenarios plus random traffic against a behavioural model.
module tb_exe_stage;

    typedef struct {
        logic [11:0] op;
        logic        rfm;
        logic [31:0] s1;
        logic [31:0] s2;
        logic        mwe;
        logic        rfwe;
        logic [4:0]  wa;
        logic [31:0] rkd;
        logic [31:0] pc;
    } bnd_t;

    logic         clk;
    logic         resetn;
    logic         id_to_exe_valid;
    logic [147:0] id_to_exe_zip;
    logic         exe_allowin;
    logic         mem_allowin;
    logic         exe_to_mem_valid;
    logic [70:0]  exe_to_mem_zip;
    logic [38:0]  exe_rf_zip;
    logic         data_sram_en;
    logic [3:0]   data_sram_we;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;
`ifdef EXE_PERF_CNT_EN
    logic [31:0]  exe_inst_cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic        m_valid;
    bnd_t        m_b;
    logic [31:0] m_cnt;

    exe_stage dut (
        .clk              (clk),
        .resetn           (resetn),
        .id_to_exe_valid  (id_to_exe_valid),
        .id_to_exe_zip    (id_to_exe_zip),
        .exe_allowin      (exe_allowin),
        .mem_allowin      (mem_allowin),
        .exe_to_mem_valid (exe_to_mem_valid),
        .exe_to_mem_zip   (exe_to_mem_zip),
        .exe_rf_zip       (exe_rf_zip),
`ifdef EXE_PERF_CNT_EN
        .exe_inst_cnt     (exe_inst_cnt),
`endif
        .data_sram_en     (data_sram_en),
        .data_sram_we     (data_sram_we),
        .data_sram_addr   (data_sram_addr),
        .data_sram_wdata  (data_sram_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [147:0] pack(bnd_t b);
        return {b.op, b.rfm, b.s1, b.s2, b.mwe, b.rfwe, b.wa, b.rkd, b.pc};
    endfunction

    function automatic bnd_t mk(int idx, logic rfm, logic mwe, logic rfwe, logic [4:0] wa,
                                logic [31:0] s1, logic [31:0] s2, logic [31:0] rkd,
                                logic [31:0] pc);
        bnd_t b;
        b.op   = (idx < 12) ? (12'd1 << idx) : 12'd0;
        b.rfm  = rfm;
        b.s1   = s1;
        b.s2   = s2;
        b.mwe  = mwe;
        b.rfwe = rfwe;
        b.wa   = wa;
        b.rkd  = rkd;
        b.pc   = pc;
        return b;
    endfunction

    // Reference ALU from the operation definitions, one term per set opcode bit
    function automatic logic [31:0] ref_alu(logic [11:0] op, logic [31:0] a, logic [31:0] b);
        logic [31:0] r;
        int sh;
        r  = 32'd0;
        sh = int'(b % 32);
        if (op[0])  r = r | (a + b);
        if (op[1])  r = r | (a - b);
        if (op[2])  r = r | (($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
        if (op[3])  r = r | ((a < b) ? 32'd1 : 32'd0);
        if (op[4])  r = r | (a & b);
        if (op[5])  r = r | ~(a | b);
        if (op[6])  r = r | (a | b);
        if (op[7])  r = r | (a ^ b);
        if (op[8])  r = r | (a << sh);
        if (op[9])  r = r | (a >> sh);
        if (op[10]) r = r | 32'($signed(a) >>> sh);
        if (op[11]) r = r | b;
        return r;
    endfunction

    function automatic bnd_t rnd_bundle();
        int kind;
        bnd_t b;
        kind = int'($urandom_range(0, 2));
        b = mk(int'($urandom_range(0, 12)), kind == 1, kind == 2, kind != 2,
               5'($urandom), $urandom, ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40)),
               $urandom, $urandom);
        return b;
    endfunction

    task automatic chk(input string tag, input logic [147:0] obs, input logic [147:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [31:0] res;
        res = ref_alu(m_b.op, m_b.s1, m_b.s2);
        chk("allowin", 148'(exe_allowin), 148'(!m_valid || mem_allowin));
        chk("to_mem_valid", 148'(exe_to_mem_valid), 148'(m_valid));
        chk("sram_en", 148'(data_sram_en), 148'(m_valid && (m_b.rfm || m_b.mwe)));
        chk("sram_we", 148'(data_sram_we), 148'({4{m_valid && m_b.mwe && resetn}}));
        chk("rf_zip_en", 148'(exe_rf_zip[38:37]), 148'({m_valid && m_b.rfm, m_valid && m_b.rfwe}));
        if (m_valid) begin
            chk("mem_zip", 148'(exe_to_mem_zip), 148'({m_b.rfm, m_b.rfwe, m_b.wa, res, m_b.pc}));
            chk("rf_zip_data", 148'(exe_rf_zip[36:0]), 148'({m_b.wa, res}));
            chk("sram_addr", 148'(data_sram_addr), 148'(res));
            chk("sram_wdata", 148'(data_sram_wdata), 148'(m_b.rkd));
        end
`ifdef EXE_PERF_CNT_EN
        chk("inst_cnt", 148'(exe_inst_cnt), 148'(m_cnt));
`endif
    endtask

    // Drive one cycle of inputs, compare outputs against the model, then advance model and clock
    task automatic cycle(input logic rst_n, input logic v, input bnd_t b, input logic ma,
                         input bit do_chk);
        resetn          = rst_n;
        id_to_exe_valid = v;
        id_to_exe_zip   = pack(b);
        mem_allowin     = ma;
        #1;
        if (do_chk) check_all();
        if (!rst_n) begin
            m_valid = 1'b0;
            m_cnt   = 32'd0;
        end else begin
            if (m_valid && ma) m_cnt = m_cnt + 32'd1;
            if (!m_valid || ma) begin
                m_valid = v;
                if (v) m_b = b;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bnd_t idle;
        bnd_t b;
        logic [70:0] snap_zip;
        logic [38:0] snap_rf;

        idle    = mk(12, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        m_valid = 1'b0;
        m_b     = idle;
        m_cnt   = 32'd0;

        cycle(1'b0, 1'b0, idle, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, idle, 1'b1, 1'b1);
        chk("reset_valid", 148'(exe_to_mem_valid), 148'(1'b0));
        chk("reset_sram_we", 148'(data_sram_we), 148'(4'h0));

        b = mk(0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h7FFFFFFF, 32'h1, 32'h0, 32'h1C000000);
        cycle(1'b1, 1'b1, b, 1'b1, 1'b1);
        chk("add_result", 148'(exe_to_mem_zip[63:32]), 148'(32'h80000000));
        chk("add_rf_zip", 148'(exe_rf_zip), 148'({1'b0, 1'b1, 5'd5, 32'h80000000}));

        b = mk(2, 1'b0, 1'b0, 1'b1, 5'd6, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h1C000004);
        cycle(1'b1, 1'b1, b, 1'b1, 1'b1);
        chk("slt", 148'(exe_rf_zip[31:0]), 148'(32'd1));
        b = mk(3, 1'b0, 1'b0, 1'b1, 5'd7, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h1C000008);
        cycle(1'b1, 1'b1, b, 1'b1, 1'b1);
        chk("sltu", 148'(exe_rf_zip[31:0]), 148'(32'd0));
        b = mk(10, 1'b0, 1'b0, 1'b1, 5'd8, 32'h80000000, 32'h1F, 32'h0, 32'h1C00000C);
        cycle(1'b1, 1'b1, b, 1'b1, 1'b1);
        chk("sra", 148'(exe_rf_zip[31:0]), 148'(32'hFFFFFFFF));

        b = mk(0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h1000, 32'h8, 32'hDEADBEEF, 32'h1C000010);
        cycle(1'b1, 1'b1, b, 1'b1, 1'b1);
        chk("st_en", 148'(data_sram_en), 148'(1'b1));
        chk("st_we", 148'(data_sram_we), 148'(4'hF));
        chk("st_addr", 148'(data_sram_addr), 148'(32'h1008));
        chk("st_wdata", 148'(data_sram_wdata), 148'(32'hDEADBEEF));
        cycle(1'b1, 1'b0, idle, 1'b1, 1'b1);
        chk("st_gone_en", 148'(data_sram_en), 148'(1'b0));

        // Load held under back-pressure while decode offers another bundle
        b = mk(0, 1'b1, 1'b0, 1'b1, 5'd9, 32'h2000, 32'h4, 32'h0, 32'h1C000014);
        cycle(1'b1, 1'b1, b, 1'b1, 1'b1);
        snap_zip = exe_to_mem_zip;
        snap_rf  = exe_rf_zip;
        b = mk(6, 1'b0, 1'b0, 1'b1, 5'd10, 32'hF0, 32'h0F, 32'h0, 32'h1C000018);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b1, b, 1'b0, 1'b1);
            chk("bp_allowin", 148'(exe_allowin), 148'(1'b0));
            chk("bp_zip_stable", 148'(exe_to_mem_zip), 148'(snap_zip));
            chk("bp_rf_stable", 148'(exe_rf_zip), 148'(snap_rf));
        end
        cycle(1'b1, 1'b1, b, 1'b1, 1'b1);
        chk("bp_release_rfm", 148'(exe_rf_zip[38]), 148'(1'b0));
        chk("bp_release_res", 148'(exe_rf_zip[31:0]), 148'(32'hFF));

        b = mk(0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h3000, 32'h0, 32'h12345678, 32'h1C00001C);
        cycle(1'b1, 1'b1, b, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, b, 1'b0, 1'b1);
        chk("rst_mid_valid", 148'(exe_to_mem_valid), 148'(1'b0));
        chk("rst_mid_we", 148'(data_sram_we), 148'(4'h0));
`ifdef EXE_PERF_CNT_EN
        chk("rst_mid_cnt", 148'(exe_inst_cnt), 148'(32'd0));
`endif

        for (int i = 0; i < 300; i++) begin
            cycle(1'b1, $urandom_range(0, 3) != 0, rnd_bundle(), $urandom_range(0, 9) < 7, 1'b1);
        end

`ifdef EXE_PERF_CNT_EN
        cycle(1'b0, 1'b0, idle, 1'b1, 1'b1);
        for (int i = 0; i < 12; i++) begin
            if (i == 3 || i == 8) cycle(1'b1, 1'b0, idle, 1'b0, 1'b1);
            else                  cycle(1'b1, 1'b1, rnd_bundle(), 1'b1, 1'b1);
        end
        cycle(1'b1, 1'b0, idle, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, idle, 1'b1, 1'b1);
        chk("cnt_ten", 148'(exe_inst_cnt), 148'(32'd10));
`endif

        cycle(1'b1, 1'b0, idle, 1'b1, 1'b1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
